// File: rtl/wb_port_arbiter_pkg.sv
// wb_port_arbiter_pkg: register-file write port widths, well-known register codes and arbitration select type.
package wb_port_arbiter_pkg;
  localparam int REG_CODE_W = 4;
  localparam int REG_DATA_W = 32;
  localparam logic [REG_CODE_W-1:0] R13 = 4'd13;
  localparam logic [REG_CODE_W-1:0] R14 = 4'd14;
  localparam logic [REG_CODE_W-1:0] R15 = 4'd15;
  typedef enum logic [1:0] {SEL_NONE, SEL_PRI, SEL_SEC} sel_t;
endpackage

// File: rtl/wb_port_arbiter_sec_fifo.sv
// wb_port_arbiter_sec_fifo: secondary write queue with per-entry WAW kill flags and a live-entry query.
module wb_port_arbiter_sec_fifo
  import wb_port_arbiter_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  push,
  input  logic [REG_CODE_W-1:0] push_code,
  input  logic [REG_DATA_W-1:0] push_data,
  input  logic                  pop,
  input  logic                  kill_en,
  input  logic [REG_CODE_W-1:0] kill_code,
  input  logic [REG_CODE_W-1:0] qry_code,
  output logic [REG_CODE_W-1:0] head_code,
  output logic [REG_DATA_W-1:0] head_data,
  output logic                  head_kill,
  output logic [AW:0]           cnt,
  output logic                  qry_hit
);
  logic [REG_CODE_W-1:0] code_q [DEPTH];
  logic [REG_DATA_W-1:0] data_q [DEPTH];
  logic [DEPTH-1:0]      kill_q, vld;
  logic [AW-1:0]         wr_ptr, rd_ptr;
  assign head_code = code_q[rd_ptr];
  assign head_data = data_q[rd_ptr];
  assign head_kill = kill_q[rd_ptr];
  // An entry is occupied when its distance from the read pointer is below the count.
  always_comb begin
    vld = '0;
    qry_hit = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      vld[i] = {1'b0, AW'(i) - rd_ptr} < cnt;
      qry_hit = qry_hit | (vld[i] & ~kill_q[i] & (code_q[i] == qry_code));
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
      kill_q <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      cnt <= cnt + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
      for (int i = 0; i < DEPTH; i++)
        if (kill_en && vld[i] && code_q[i] == kill_code) kill_q[i] <= 1'b1;
      if (push) kill_q[wr_ptr] <= kill_en && push_code == kill_code;
    end
  end
  always_ff @(posedge clk) begin
    if (push) begin
      code_q[wr_ptr] <= push_code;
      data_q[wr_ptr] <= push_data;
    end
  end
endmodule

// File: rtl/wb_port_arbiter.sv
// wb_port_arbiter: shares the register-file write port between the WB pipeline and a queued secondary source.
module wb_port_arbiter
  import wb_port_arbiter_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int MAX_WAIT = 3,
  localparam int CW = $clog2(FIFO_DEPTH) + 1,
  localparam int WW = $clog2(MAX_WAIT + 1)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_pri_vld,
  input  logic [REG_CODE_W-1:0] i_pri_code,
  input  logic [REG_DATA_W-1:0] i_pri_data,
  output logic                  o_pri_stall,
  input  logic                  i_sec_vld,
  output logic                  o_sec_rdy,
  input  logic [REG_CODE_W-1:0] i_sec_code,
  input  logic [REG_DATA_W-1:0] i_sec_data,
  output logic                  o_rf_we,
  output logic [REG_CODE_W-1:0] o_rf_code,
  output logic [REG_DATA_W-1:0] o_rf_data,
  input  logic [REG_CODE_W-1:0] i_qry_code,
  output logic                  o_qry_hit,
  output logic [CW-1:0]         o_fifo_cnt
);
  logic [REG_CODE_W-1:0] head_code;
  logic [REG_DATA_W-1:0] head_data;
  logic                  head_kill, empty, pop, fifo_hit;
  logic [WW-1:0]         wait_cnt;
  sel_t                  sel;
  assign empty = o_fifo_cnt == '0;
  assign o_sec_rdy = o_fifo_cnt < CW'(FIFO_DEPTH);
  assign o_pri_stall = (wait_cnt >= WW'(MAX_WAIT)) & ~empty;
  assign pop = ~(i_pri_vld & ~o_pri_stall) & ~empty;
  // A killed head is still popped but produces no write.
  assign sel = (i_pri_vld & ~o_pri_stall) ? SEL_PRI : (pop & ~head_kill) ? SEL_SEC : SEL_NONE;
  assign o_qry_hit = fifo_hit | (o_rf_we & (o_rf_code == i_qry_code));
  wb_port_arbiter_sec_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (i_sec_vld & o_sec_rdy),
    .push_code (i_sec_code),
    .push_data (i_sec_data),
    .pop       (pop),
    .kill_en   (sel == SEL_PRI),
    .kill_code (i_pri_code),
    .qry_code  (i_qry_code),
    .head_code (head_code),
    .head_data (head_data),
    .head_kill (head_kill),
    .cnt       (o_fifo_cnt),
    .qry_hit   (fifo_hit)
  );
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_rf_we   <= 1'b0;
      o_rf_code <= '0;
      o_rf_data <= '0;
      wait_cnt  <= '0;
    end else begin
      o_rf_we <= sel != SEL_NONE;
      if (sel == SEL_PRI) begin
        o_rf_code <= i_pri_code;
        o_rf_data <= i_pri_data;
      end else if (sel == SEL_SEC) begin
        o_rf_code <= head_code;
        o_rf_data <= head_data;
      end
      wait_cnt <= (pop | empty) ? '0 :
                  (sel == SEL_PRI && wait_cnt < WW'(MAX_WAIT)) ? wait_cnt + WW'(1) : wait_cnt;
    end
  end
endmodule

// File: tb/tb_wb_port_arbiter.sv
// tb_wb_port_arbiter: directed scenarios checked every cycle against a queue-based model plus literal expectations.
module tb_wb_port_arbiter;
  logic        clk = 1'b0, rst_n = 1'b1;
  logic        pri_vld = 1'b0, sec_vld = 1'b0;
  logic [3:0]  pri_code = '0, sec_code = '0, qry_code = '0;
  logic [31:0] pri_data = '0, sec_data = '0;
  logic        o_pri_stall, o_sec_rdy, o_rf_we, o_qry_hit;
  logic [3:0]  o_rf_code;
  logic [31:0] o_rf_data;
  logic [2:0]  o_fifo_cnt;
  int checks = 0, failures = 0;
  always #5 clk = ~clk;
  wb_port_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .i_pri_vld(pri_vld), .i_pri_code(pri_code), .i_pri_data(pri_data), .o_pri_stall(o_pri_stall),
    .i_sec_vld(sec_vld), .o_sec_rdy(o_sec_rdy), .i_sec_code(sec_code), .i_sec_data(sec_data),
    .o_rf_we(o_rf_we), .o_rf_code(o_rf_code), .o_rf_data(o_rf_data),
    .i_qry_code(qry_code), .o_qry_hit(o_qry_hit), .o_fifo_cnt(o_fifo_cnt)
  );
  typedef struct {logic [3:0] code; logic [31:0] data; bit kill;} ent_t;
  ent_t        mq[$];
  int          wc;
  bit          m_we;
  logic [3:0]  m_code;
  logic [31:0] m_data;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask
  function automatic bit m_stall();
    return wc >= 3 && mq.size() > 0;
  endfunction
  function automatic bit m_hit(input logic [3:0] q);
    foreach (mq[i]) if (!mq[i].kill && mq[i].code == q) return 1'b1;
    return m_we && m_code == q;
  endfunction
  always @(posedge clk or negedge rst_n) begin
    bit ps, popped, emp;
    int n;
    ent_t e;
    if (!rst_n) begin
      mq.delete();
      wc = 0;
      m_we = 0;
      m_code = '0;
      m_data = '0;
    end else begin
      n = mq.size();
      emp = n == 0;
      ps = pri_vld && !m_stall();
      popped = 0;
      if (ps) begin
        foreach (mq[i]) if (mq[i].code == pri_code) mq[i].kill = 1;
        m_we = 1;
        m_code = pri_code;
        m_data = pri_data;
      end else if (!emp) begin
        e = mq.pop_front();
        popped = 1;
        m_we = !e.kill;
        if (!e.kill) begin
          m_code = e.code;
          m_data = e.data;
        end
      end else m_we = 0;
      if (sec_vld && n < 4) mq.push_back('{sec_code, sec_data, ps && sec_code == pri_code});
      if (popped || emp) wc = 0;
      else if (ps && wc < 3) wc++;
    end
  end
  always @(negedge clk) begin
    if (rst_n) begin
      chk("pri_stall", o_pri_stall, m_stall());
      chk("sec_rdy", o_sec_rdy, mq.size() < 4);
      chk("fifo_cnt", o_fifo_cnt, mq.size());
      chk("qry_hit", o_qry_hit, m_hit(qry_code));
      chk("rf_we", o_rf_we, m_we);
      chk("rf_code", o_rf_code, m_code);
      chk("rf_data", o_rf_data, m_data);
    end
  end
  task automatic drv(input logic pv, input logic [3:0] pc, input logic [31:0] pd,
                     input logic sv, input logic [3:0] sc, input logic [31:0] sd, input logic [3:0] qc);
    pri_vld = pv; pri_code = pc; pri_data = pd;
    sec_vld = sv; sec_code = sc; sec_data = sd; qry_code = qc;
    @(posedge clk);
    #2;
  endtask
  task automatic reset_vals(input string tag);
    chk({tag, "_we"}, o_rf_we, 0);
    chk({tag, "_code"}, o_rf_code, 0);
    chk({tag, "_data"}, o_rf_data, 0);
    chk({tag, "_cnt"}, o_fifo_cnt, 0);
    chk({tag, "_rdy"}, o_sec_rdy, 1);
    chk({tag, "_stall"}, o_pri_stall, 0);
    chk({tag, "_hit"}, o_qry_hit, 0);
  endtask
  initial begin
    #1 rst_n = 1'b0;
    #2 reset_vals("rst");
    @(posedge clk); @(posedge clk); #2 rst_n = 1'b1;
    // primary only
    drv(1, 3, 32'hDEADBEEF, 0, 0, 0, 3);
    chk("t1_we", o_rf_we, 1); chk("t1_code", o_rf_code, 3);
    chk("t1_data", o_rf_data, 32'hDEADBEEF); chk("t1_cnt", o_fifo_cnt, 0); chk("t1_hit", o_qry_hit, 1);
    // secondary into idle port: no bypass
    drv(0, 0, 0, 1, 13, 32'h1000, 0);
    chk("t2_cnt1", o_fifo_cnt, 1); chk("t2_we0", o_rf_we, 0);
    drv(0, 0, 0, 0, 0, 0, 0);
    chk("t2_we", o_rf_we, 1); chk("t2_code", o_rf_code, 13);
    chk("t2_data", o_rf_data, 32'h1000); chk("t2_cnt0", o_fifo_cnt, 0);
    // starvation
    drv(0, 0, 0, 1, 5, 32'h55, 0);
    for (int i = 0; i < 3; i++) begin
      chk("t3_nostall", o_pri_stall, 0);
      drv(1, 1, 32'h111, 0, 0, 0, 0);
      chk("t3_pri", o_rf_code, 1);
    end
    chk("t3_stall", o_pri_stall, 1);
    drv(1, 1, 32'h111, 0, 0, 0, 0);
    chk("t3_sec_code", o_rf_code, 5); chk("t3_sec_data", o_rf_data, 32'h55); chk("t3_unstall", o_pri_stall, 0);
    drv(1, 1, 32'h111, 0, 0, 0, 0);
    chk("t3_resume", o_rf_code, 1);
    // WAW kill
    drv(1, 2, 32'h20, 1, 7, 32'hA, 7);
    chk("t4_hit_q", o_qry_hit, 1);
    drv(1, 7, 32'hB, 0, 0, 0, 7);
    chk("t4_pri_data", o_rf_data, 32'hB); chk("t4_cnt", o_fifo_cnt, 1);
    drv(0, 0, 0, 0, 0, 0, 7);
    chk("t4_killed_we", o_rf_we, 0); chk("t4_hit_gone", o_qry_hit, 0);
    chk("t4_hold", o_rf_data, 32'hB); chk("t4_cnt0", o_fifo_cnt, 0);
    // full FIFO, held request, pointer wrap
    for (int i = 0; i < 4; i++) drv(1, 1, 32'h100 + i, 1, 4'(8 + i), 32'h80 + 32'(i) * 32'h10, 0);
    chk("t5_full", o_fifo_cnt, 4); chk("t5_rdy0", o_sec_rdy, 0); chk("t5_stall", o_pri_stall, 1);
    drv(1, 1, 32'h104, 1, 12, 32'hC0, 0);
    chk("t5_pop8", o_rf_code, 8); chk("t5_cnt3", o_fifo_cnt, 3);
    drv(1, 1, 32'h104, 1, 12, 32'hC0, 0);
    chk("t5_refull", o_fifo_cnt, 4);
    drv(0, 0, 0, 0, 0, 0, 0);
    chk("t5_pop9", o_rf_code, 9);
    drv(0, 0, 0, 1, 13, 32'hD0, 0);
    chk("t5_pushpop_cnt", o_fifo_cnt, 3); chk("t5_pop10", o_rf_code, 10);
    drv(0, 0, 0, 0, 0, 0, 0);
    drv(0, 0, 0, 0, 0, 0, 0);
    chk("t5_pop12", o_rf_data, 32'hC0);
    drv(0, 0, 0, 0, 0, 0, 0);
    chk("t5_pop13", o_rf_data, 32'hD0); chk("t5_empty", o_fifo_cnt, 0);
    // reset mid-operation
    for (int i = 0; i < 3; i++) drv(1, 2, 32'h200, 1, 4'(4 + i), 32'h40, 2);
    chk("t6_cnt3", o_fifo_cnt, 3);
    rst_n = 1'b0;
    #1 reset_vals("t6");
    drv(0, 0, 0, 0, 0, 0, 4);
    drv(0, 0, 0, 0, 0, 0, 4);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) drv(0, 0, 0, 0, 0, 0, 4);
    chk("t6_nowrite", o_rf_we, 0); chk("t6_cnt0", o_fifo_cnt, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
